rd_burst_sched: RTL and testbench

RD_BURST_SCHED -- requirements
Module: rd_burst_sched

---
 rtl/rd_burst_sched.sv | 135 +++++++++++++
 tb/tb_rd_burst_sched.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_burst_sched.sv
// ---------------------------------------------------------------------------
// rd_burst_sched
//
// Read-side burst scheduler for an asynchronous FIFO. It pops words from the
// FIFO head and presents them downstream as valid/ready bursts of
// 1..BURSTLEN beats. The final beat of every burst carries m_last.
//
// A beat popped mid-burst is held in m_data. It is only offered as a
// non-last beat once a successor word is already visible in the FIFO. If the
// FIFO stays empty for more than tmo_cfg cycles while a beat is held, that
// beat is released as the last one and tmo_end pulses.
//
// Ports
//   rclk     in   read-domain clock
//   rrst_n   in   asynchronous active-low reset
//   en       in   permits new bursts to start (in-flight bursts always finish)
//   tmo_cfg  in   idle cycles tolerated mid-burst before forced termination
//   rempty   in   FIFO empty flag (rclk domain)
//   rdata    in   FIFO head word, valid while rempty=0
//   rinc     out  FIFO pop strobe (combinational)
//   m_valid  out  downstream beat valid
//   m_ready  in   downstream ready
//   m_data   out  downstream beat data (registered)
//   m_last   out  last beat of the burst
//   busy     out  a burst is in progress
//   tmo_end  out  one-cycle pulse when a burst is closed by timeout
// ---------------------------------------------------------------------------
module rd_burst_sched #(
  parameter int DSIZE    = 8,
  parameter int BURSTLEN = 4,
  parameter int TMOW     = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             en,
  input  logic [TMOW-1:0]  tmo_cfg,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             tmo_end
);

  localparam int BW = $clog2(BURSTLEN + 1);
  localparam logic [BW-1:0] BEAT_ONE = BW'(1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURSTLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t            state_reg;
  logic [BW-1:0]     bcnt_reg;
  logic [TMOW-1:0]   tcnt_reg;

  // Pop strobe. In HOLD a pop is also the handshake that retires the held
  // beat, so it requires m_ready. Gating with rrst_n keeps the FIFO untouched
  // while reset is asserted, even though IDLE would otherwise pop.
  always_comb begin
    rinc = 1'b0;
    if (rrst_n && !rempty) begin
      case (state_reg)
        IDLE:    rinc = en;
        HOLD:    rinc = m_ready;
        default: rinc = 1'b0;
      endcase
    end
  end

  // In HOLD the held beat is offered only while a successor word is visible.
  // This block is the only FIFO reader, so rempty cannot rise again until
  // we pop, which keeps m_valid stable once asserted.
  assign m_valid = (state_reg == LAST) || ((state_reg == HOLD) && !rempty);
  assign m_last  = (state_reg == LAST);
  assign busy    = (state_reg != IDLE);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_reg <= IDLE;
      bcnt_reg  <= '0;
      tcnt_reg  <= '0;
      m_data    <= '0;
      tmo_end   <= 1'b0;
    end else begin
      tmo_end <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (en && !rempty) begin
            m_data    <= rdata;
            bcnt_reg  <= BEAT_ONE;
            tcnt_reg  <= '0;
            state_reg <= (BURSTLEN == 1) ? LAST : HOLD;
          end
        end

        HOLD: begin
          if (!rempty) begin
            // A successor exists; the held beat goes out when ready and
            // the successor takes its place in m_data.
            if (m_ready) begin
              m_data   <= rdata;
              bcnt_reg <= bcnt_reg + BEAT_ONE;
              tcnt_reg <= '0;
              if ((bcnt_reg + BEAT_ONE) == BEAT_MAX) begin
                state_reg <= LAST;
              end
            end
          end else if (tcnt_reg == tmo_cfg) begin
            // Starved for tmo_cfg+1 cycles: close the burst on the held beat.
            state_reg <= LAST;
            tmo_end   <= 1'b1;
          end else begin
            tcnt_reg <= tcnt_reg + TMOW'(1);
          end
        end

        LAST: begin
          if (m_ready) begin
            state_reg <= IDLE;
            bcnt_reg  <= '0;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_burst_sched.sv
// ---------------------------------------------------------------------------
// tb_rd_burst_sched
//
// Self-checking bench for rd_burst_sched. Two instances are built: dut_a
// with BURSTLEN=4 and dut_b with BURSTLEN=1. They share the FIFO model and
// most inputs, and only the instance selected by 'sel' is enabled at any
// time. The FIFO is a queue, and pops are applied right after the clock
// edge at which rinc was high. Outputs are sampled on the falling edge.
// Expected behaviour comes from burst-level rules: one idle cycle followed
// by BURSTLEN beats, a timeout after tmo_cfg+1 empty cycles, and in-order
// delivery.
// ---------------------------------------------------------------------------
module tb_rd_burst_sched;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int TW = 8;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          en_a, en_b;
  logic [TW-1:0] tmo_cfg;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          m_ready;

  logic          rinc_a, mv_a, ml_a, busy_a, te_a;
  logic [DW-1:0] md_a;
  logic          rinc_b, mv_b, ml_b, busy_b, te_b;
  logic [DW-1:0] md_b;

  rd_burst_sched #(.DSIZE(DW), .BURSTLEN(BL), .TMOW(TW)) dut_a (
    .rclk(rclk), .rrst_n(rrst_n), .en(en_a), .tmo_cfg(tmo_cfg),
    .rempty(rempty), .rdata(rdata), .rinc(rinc_a), .m_valid(mv_a),
    .m_ready(m_ready), .m_data(md_a), .m_last(ml_a), .busy(busy_a),
    .tmo_end(te_a)
  );

  rd_burst_sched #(.DSIZE(DW), .BURSTLEN(1), .TMOW(TW)) dut_b (
    .rclk(rclk), .rrst_n(rrst_n), .en(en_b), .tmo_cfg(tmo_cfg),
    .rempty(rempty), .rdata(rdata), .rinc(rinc_b), .m_valid(mv_b),
    .m_ready(m_ready), .m_data(md_b), .m_last(ml_b), .busy(busy_b),
    .tmo_end(te_b)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;
  int rinc_count = 0;
  bit sel = 1'b0;

  logic [DW-1:0] fifo[$];

  logic          s_rinc, s_valid, s_last, s_busy, s_tmo, s_rempty, s_ready;
  logic [DW-1:0] s_data;

  task automatic upd_fifo();
    rempty = (fifo.size() == 0);
    rdata  = rempty ? '0 : fifo[0];
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo.push_back(w);
    upd_fifo();
  endtask

  // Sample the selected instance on the falling edge, then advance past the
  // rising edge and apply any pop it requested.
  task automatic step();
    @(negedge rclk);
    s_rinc   = sel ? rinc_b : rinc_a;
    s_valid  = sel ? mv_b   : mv_a;
    s_last   = sel ? ml_b   : ml_a;
    s_busy   = sel ? busy_b : busy_a;
    s_tmo    = sel ? te_b   : te_a;
    s_data   = sel ? md_b   : md_a;
    s_rempty = rempty;
    s_ready  = m_ready;
    @(posedge rclk);
    #1;
    if (s_rinc && fifo.size() > 0) begin
      void'(fifo.pop_front());
      rinc_count++;
    end
    upd_fifo();
  endtask

  task automatic do_reset();
    rrst_n  = 1'b0;
    en_a    = 1'b0;
    en_b    = 1'b0;
    m_ready = 1'b0;
    tmo_cfg = '0;
    fifo.delete();
    upd_fifo();
    @(posedge rclk); #1;
    @(posedge rclk); #1;
    rrst_n = 1'b1;
  endtask

  task automatic test_reset();
    rrst_n  = 1'b0;
    en_a    = 1'b1;
    en_b    = 1'b1;
    m_ready = 1'b1;
    tmo_cfg = 8'd3;
    fifo.delete();
    for (int k = 0; k < 3; k++) push(DW'($urandom));
    for (int k = 0; k < 2; k++) begin
      @(negedge rclk);
      checks++;
      if ({rinc_a, mv_a, ml_a, busy_a, te_a} !== 5'b0 || md_a !== '0) begin
        errors++;
        $display("FAIL reset_a: rinc/valid/last/busy/tmo=%b%b%b%b%b data=%h required 00000 data=00",
                 rinc_a, mv_a, ml_a, busy_a, te_a, md_a);
      end
      checks++;
      if ({rinc_b, mv_b, ml_b, busy_b, te_b} !== 5'b0 || md_b !== '0) begin
        errors++;
        $display("FAIL reset_b: rinc/valid/last/busy/tmo=%b%b%b%b%b data=%h required 00000 data=00",
                 rinc_b, mv_b, ml_b, busy_b, te_b, md_b);
      end
      @(posedge rclk); #1;
    end
    $display("test_reset done");
  endtask

  // Drains the words currently queued as full bursts of 'bl' beats with
  // m_ready held high. Each burst is one idle/pop cycle followed by bl beats.
  task automatic test_bursts(input bit s, input int bl, input string name);
    logic [DW-1:0] w[$];
    logic          e_rinc, e_valid, e_last, e_busy;
    logic [DW-1:0] e_data;
    int            n;
    w = fifo;
    n = w.size();
    sel = s;
    m_ready = 1'b1;
    rinc_count = 0;
    if (s) en_b = 1'b1; else en_a = 1'b1;
    for (int c = 0; c < (n / bl) * (bl + 1); c++) begin
      int b, i;
      b = c / (bl + 1);
      i = c % (bl + 1);
      if (i == 0) begin
        e_rinc = 1'b1; e_valid = 1'b0; e_last = 1'b0; e_busy = 1'b0; e_data = '0;
      end else begin
        e_rinc  = (i < bl);
        e_valid = 1'b1;
        e_last  = (i == bl);
        e_busy  = 1'b1;
        e_data  = w[b * bl + i - 1];
      end
      step();
      checks++;
      if ({s_rinc, s_valid, s_last, s_busy} !== {e_rinc, e_valid, e_last, e_busy} ||
          (e_valid && s_data !== e_data)) begin
        errors++;
        $display("FAIL %s cycle %0d: rinc/valid/last/busy=%b%b%b%b data=%h required %b%b%b%b data=%h",
                 name, c, s_rinc, s_valid, s_last, s_busy, s_data,
                 e_rinc, e_valid, e_last, e_busy, e_data);
      end
    end
    en_a = 1'b0;
    en_b = 1'b0;
    step();
    checks++;
    if ({s_rinc, s_valid, s_busy} !== 3'b000) begin
      errors++;
      $display("FAIL %s_idle: rinc/valid/busy=%b%b%b required 000", name, s_rinc, s_valid, s_busy);
    end
    checks++;
    if (rinc_count != n) begin
      errors++;
      $display("FAIL %s_pops: rinc pulses=%0d required %0d", name, rinc_count, n);
    end
    $display("%s done: %0d words in bursts of %0d", name, n, bl);
  endtask

  task automatic test_two_bursts();
    do_reset();
    for (int k = 0; k < 8; k++) push(DW'($urandom));
    test_bursts(1'b0, BL, "two_bursts");
  endtask

  task automatic test_burstlen1();
    do_reset();
    for (int k = 0; k < 5; k++) push(DW'($urandom));
    test_bursts(1'b1, 1, "burstlen1");
  endtask

  // Two words then starvation: beat 1 goes out, beat 2 is held for t+1 empty
  // cycles and then released as last together with the tmo_end pulse.
  task automatic test_timeout(input int t);
    logic [DW-1:0] w0, w1;
    logic          e_rinc, e_valid, e_last, e_busy, e_tmo;
    logic [DW-1:0] e_data;
    do_reset();
    sel = 1'b0;
    m_ready = 1'b1;
    tmo_cfg = TW'(t);
    w0 = DW'($urandom);
    w1 = DW'($urandom);
    push(w0);
    push(w1);
    en_a = 1'b1;
    for (int c = 0; c <= t + 4; c++) begin
      e_rinc = 1'b0; e_valid = 1'b0; e_last = 1'b0; e_busy = 1'b1; e_tmo = 1'b0; e_data = '0;
      if (c == 0) begin
        e_rinc = 1'b1; e_busy = 1'b0;
      end else if (c == 1) begin
        e_rinc = 1'b1; e_valid = 1'b1; e_data = w0;
      end else if (c == t + 3) begin
        e_valid = 1'b1; e_last = 1'b1; e_tmo = 1'b1; e_data = w1;
      end else if (c == t + 4) begin
        e_busy = 1'b0;
      end
      step();
      checks++;
      if ({s_rinc, s_valid, s_last, s_busy, s_tmo} !== {e_rinc, e_valid, e_last, e_busy, e_tmo} ||
          (e_valid && s_data !== e_data)) begin
        errors++;
        $display("FAIL timeout%0d cycle %0d: rinc/valid/last/busy/tmo=%b%b%b%b%b data=%h required %b%b%b%b%b data=%h",
                 t, c, s_rinc, s_valid, s_last, s_busy, s_tmo, s_data,
                 e_rinc, e_valid, e_last, e_busy, e_tmo, e_data);
      end
    end
    $display("test_timeout tmo_cfg=%0d done", t);
  endtask

  task automatic test_en();
    logic [DW-1:0] w[$];
    do_reset();
    sel = 1'b0;
    m_ready = 1'b1;
    tmo_cfg = 8'd10;
    for (int k = 0; k < 5; k++) push(DW'($urandom));
    w = fifo;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({s_rinc, s_busy, s_valid} !== 3'b000) begin
        errors++;
        $display("FAIL en_off: rinc/busy/valid=%b%b%b required 000", s_rinc, s_busy, s_valid);
      end
    end
    en_a = 1'b1;
    step();
    en_a = 1'b0;
    checks++;
    if ({s_rinc, s_valid} !== 2'b10) begin
      errors++;
      $display("FAIL en_start: rinc/valid=%b%b required 10", s_rinc, s_valid);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (s_valid !== 1'b1 || s_data !== w[k] || s_last !== (k == 3)) begin
        errors++;
        $display("FAIL en_midburst beat %0d: valid=%b data=%h last=%b required 1 data=%h last=%b",
                 k, s_valid, s_data, s_last, w[k], (k == 3));
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({s_rinc, s_busy, s_valid} !== 3'b000) begin
        errors++;
        $display("FAIL en_after: rinc/busy/valid=%b%b%b required 000", s_rinc, s_busy, s_valid);
      end
    end
    $display("test_en done");
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] w[$];
    do_reset();
    sel = 1'b0;
    m_ready = 1'b1;
    tmo_cfg = 8'd20;
    for (int k = 0; k < 6; k++) push(DW'($urandom));
    w = fifo;
    en_a = 1'b1;
    step();
    step();
    m_ready = 1'b0;
    step();
    checks++;
    if ({s_valid, s_busy, s_last} !== 3'b110 || s_data !== w[1]) begin
      errors++;
      $display("FAIL midrst_hold: valid/busy/last=%b%b%b data=%h required 110 data=%h",
               s_valid, s_busy, s_last, s_data, w[1]);
    end
    rrst_n = 1'b0;
    #2;
    checks++;
    if ({rinc_a, mv_a, ml_a, busy_a, te_a} !== 5'b0 || md_a !== '0) begin
      errors++;
      $display("FAIL midrst_async: rinc/valid/last/busy/tmo=%b%b%b%b%b data=%h required 00000 data=00",
               rinc_a, mv_a, ml_a, busy_a, te_a, md_a);
    end
    fifo.delete();
    for (int k = 0; k < 4; k++) push(DW'($urandom));
    @(posedge rclk); #1;
    checks++;
    if ({rinc_a, mv_a, busy_a} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_held: rinc/valid/busy=%b%b%b required 000", rinc_a, mv_a, busy_a);
    end
    rrst_n = 1'b1;
    en_a = 1'b0;
    test_bursts(1'b0, BL, "after_reset");
  endtask

  // Random pushes and random backpressure over 100 words, checked against an
  // in-order scoreboard plus burst-length and stall-stability rules.
  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] w, p_data;
    logic          p_valid, p_ready, p_last;
    int            sent, got, bcnt, cyc;
    bit            tmo_seen;
    do_reset();
    sel = 1'b0;
    tmo_cfg = 8'd255;
    en_a = 1'b1;
    sent = 0; got = 0; bcnt = 0; cyc = 0; tmo_seen = 1'b0;
    p_valid = 1'b0; p_ready = 1'b0; p_last = 1'b0; p_data = '0;
    while (got < 100 && cyc < 4000) begin
      if (sent < 100 && $urandom_range(0, 2) != 0) begin
        w = DW'($urandom);
        push(w);
        exp_q.push_back(w);
        sent++;
      end
      m_ready = ($urandom_range(0, 2) != 0);
      step();
      cyc++;
      checks++;
      if (s_rinc && s_rempty) begin
        errors++;
        $display("FAIL rnd_rinc_empty cycle %0d: rinc=1 rempty=1 required rinc=0", cyc);
      end
      if (p_valid && !p_ready) begin
        checks++;
        if ({s_valid, s_last, s_data} !== {1'b1, p_last, p_data}) begin
          errors++;
          $display("FAIL rnd_stable cycle %0d: valid/last/data=%b/%b/%h required 1/%b/%h",
                   cyc, s_valid, s_last, s_data, p_last, p_data);
        end
      end
      if (s_tmo) tmo_seen = 1'b1;
      if (s_valid && s_ready) begin
        got++;
        bcnt++;
        checks++;
        if (exp_q.size() == 0 || s_data !== exp_q[0]) begin
          errors++;
          $display("FAIL rnd_order beat %0d: data=%h required %h", got, s_data,
                   (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        checks++;
        if (s_last !== ((bcnt == BL) || tmo_seen)) begin
          errors++;
          $display("FAIL rnd_last beat %0d: last=%b required %b (beat %0d of burst)",
                   got, s_last, ((bcnt == BL) || tmo_seen), bcnt);
        end
        if (s_last) begin
          bcnt = 0;
          tmo_seen = 1'b0;
        end
      end
      p_valid = s_valid;
      p_ready = s_ready;
      p_last  = s_last;
      p_data  = s_data;
    end
    checks++;
    if (got != 100) begin
      errors++;
      $display("FAIL rnd_count: beats=%0d required 100", got);
    end
    en_a = 1'b0;
    m_ready = 1'b1;
    step();
    step();
    checks++;
    if (s_busy !== 1'b0 || fifo.size() != 0) begin
      errors++;
      $display("FAIL rnd_drain: busy=%b fifo=%0d required busy=0 fifo=0", s_busy, fifo.size());
    end
    $display("test_random done: %0d beats in %0d cycles", got, cyc);
  endtask

  initial begin
    rrst_n  = 1'b0;
    en_a    = 1'b0;
    en_b    = 1'b0;
    m_ready = 1'b0;
    tmo_cfg = '0;
    upd_fifo();
    test_reset();
    test_two_bursts();
    test_burstlen1();
    test_timeout(3);
    test_timeout(0);
    test_en();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
